ai_av_reader: RTL and testbench
===============================

Name: ai_av_reader

Overview:
- Avalon-MM read-side slave for the AI comparer: the CPU-facing counterpart of the comparer's configuration write port.
- Collects the per-template score stream from the comparer core, tracks best score/index and the count of above-threshold hits, and exposes status/results to the CPU.
- Sits on the same s0 slave as the configuration write port, sharing its init pulse and score_minimum.

Parameters:
SCORE_W, 24, width of comparer score (matches max register width)
IDX_W, 16, width of template index / counters
ADDR_W, 4, Avalon address width

Ports:
clk  in  1  clock
rst  in  1  reset
avs_s0_read  in  1  Avalon read strobe
avs_s0_address  in  ADDR_W  register select
avs_s0_readdata  out  32  read data
avs_s0_readdatavalid  out  1  read data valid
init  in  1  start pulse from config write port
score_minimum  in  8  hit threshold, compared against score[SCORE_W-1 -: 8]
score_valid  in  1  score strobe from comparer core
score  in  SCORE_W  score for current template
score_last  in  1  qualifies final score of the run
irq  out  1  done interrupt (present only with AI_AV_READER_IRQ_EN)

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): state=IDLE; best_score, best_idx, hit_count, score_cnt, done all 0; avs_s0_readdata=0; avs_s0_readdatavalid=0; irq=0.
- FSM: IDLE, RUN, DONE.
  - init in any state -> RUN next cycle. Clears best_score, best_idx, hit_count, score_cnt and done.
  - RUN with score_valid:
    - If score > best_score (strict, unsigned): best_score<=score, best_idx<=score_cnt. Ties keep the earliest index.
    - If score[SCORE_W-1 -: 8] >= score_minimum: hit_count++, saturating at 2^IDX_W-1.
    - score_cnt++, saturating at 2^IDX_W-1. Once saturated, best_idx updates use the saturated value.
  - RUN with score_valid & score_last: the sample is processed, then -> DONE, done<=1.
  - DONE: score_valid ignored; stays until init. Rst -> IDLE.
  - IDLE: score_valid ignored.
- Simultaneous init & score_valid: init wins; the sample is discarded.
- Reset mid-RUN: immediate return to IDLE with all results cleared; no done event.
- Register map (read), 32-bit, zero-extended:
  - 0 STATUS: [0]=busy (state==RUN), [1]=done, [2]=hit_count!=0.
  - 1 BEST_SCORE: [SCORE_W-1:0].
  - 2 RESULT: [31:16]=best_idx, [15:0]=hit_count.
  - 3 COUNT: [15:0]=score_cnt.
  - Others: 0.
- Read latency fixed 1: avs_s0_read at cycle N -> readdata/readdatavalid at N+1. Readdatavalid is a one-cycle pulse per read; back-to-back reads are supported every cycle. Readdata holds its last value when not valid. No waitrequest.
- Read data reflects register values at cycle N; updates in cycle N are visible from cycle N+1.
- Reading STATUS clears done at N+1. If a done event coincides, set wins and done stays 1. If init coincides, done is 0 (init clear).

Optional Feature:
- AI_AV_READER_IRQ_EN defined: irq port present; irq = registered done & irq_mask. irq_mask is write-only at address 0 bit 0 via added avs_s0_write/avs_s0_writedata inputs, reset 0. irq deasserts the cycle after the STATUS read that clears done.
- Not defined: no irq, no mask, no write inputs; read behaviour identical.

Decomposition:
- Shared package ai_av_pkg:
  - register address constants: AI_REG_STATUS=0, AI_REG_BEST=1, AI_REG_RESULT=2, AI_REG_COUNT=3.
  - STATUS bit positions.
  - FSM state typedef (IDLE/RUN/DONE).
  - SCORE_W/IDX_W defaults.
- Sub-module ai_score_tracker: best/hit/count update logic with saturation, driven by clear and sample_en. The top holds the FSM, done flag and Avalon read mux.

Test Plan:
- Reset then read addr 0 -> readdatavalid one cycle later, readdata=0x0.
- score_minimum=0x10, init, scores 0x050000, 0x200000, 0x200000, 0x0F0000(last) -> BEST=0x200000, RESULT=0x0001_0002, COUNT=4, STATUS=0x6.
- Read STATUS twice after done -> first returns done=1, second returns 0x4; state stays DONE, scores ignored.
- init in the same cycle as score_valid(0x7FFFFF) -> sample dropped, BEST=0 after next last-only run with score 0x000001 -> BEST=1.
- rst asserted mid-RUN after 3 scores -> all registers read 0, busy=0; later scores ignored until init.
- Back-to-back reads addr 1,2,3 on consecutive cycles -> three consecutive readdatavalid pulses with matching data order.

Source files
------------

// File: rtl/ai_av_pkg.sv
// rtl/ai_av_pkg.sv - shared constants and types for the AI comparer read-side slave
package ai_av_pkg;

    localparam int SCORE_W_DEF = 24;
    localparam int IDX_W_DEF   = 16;

    localparam int AI_REG_STATUS = 0;
    localparam int AI_REG_BEST   = 1;
    localparam int AI_REG_RESULT = 2;
    localparam int AI_REG_COUNT  = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_HIT  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } ai_state_t;

endpackage

// File: rtl/ai_score_tracker.sv
// rtl/ai_score_tracker.sv - best score/index, hit count and sample count with saturation
module ai_score_tracker
    import ai_av_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               sample_en,
    input  logic [SCORE_W-1:0] score,
    input  logic [7:0]         score_minimum,
    output logic [SCORE_W-1:0] best_score,
    output logic [IDX_W-1:0]   best_idx,
    output logic [IDX_W-1:0]   hit_count,
    output logic [IDX_W-1:0]   score_cnt
);

    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_score <= '0;
            best_idx   <= '0;
            hit_count  <= '0;
            score_cnt  <= '0;
        end else if (sample_en) begin
            // strict compare so ties keep the earliest index
            if (score > best_score) begin
                best_score <= score;
                best_idx   <= score_cnt;
            end
            if (score[SCORE_W-1 -: 8] >= score_minimum && hit_count != CNT_MAX)
                hit_count <= hit_count + IDX_W'(1);
            if (score_cnt != CNT_MAX)
                score_cnt <= score_cnt + IDX_W'(1);
        end
    end

endmodule

// File: rtl/ai_av_reader.sv
// rtl/ai_av_reader.sv - Avalon-MM read slave for comparer results; AI_AV_READER_IRQ_EN adds irq/mask
module ai_av_reader
    import ai_av_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               avs_s0_read,
    input  logic [ADDR_W-1:0]  avs_s0_address,
    output logic [31:0]        avs_s0_readdata,
    output logic               avs_s0_readdatavalid,
`ifdef AI_AV_READER_IRQ_EN
    input  logic               avs_s0_write,
    input  logic [31:0]        avs_s0_writedata,
    output logic               irq,
`endif
    input  logic               init,
    input  logic [7:0]         score_minimum,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_last
);

    ai_state_t          state_q, state_d;
    logic               done_q;
    logic               sample_en, done_set, status_rd;
    logic [SCORE_W-1:0] best_score;
    logic [IDX_W-1:0]   best_idx, hit_count, score_cnt;
    logic [31:0]        rd_mux;

    // init overrides any coincident sample
    assign sample_en = (state_q == S_RUN) && score_valid && !init;
    assign done_set  = sample_en && score_last;
    assign status_rd = avs_s0_read && (avs_s0_address == ADDR_W'(AI_REG_STATUS));

    ai_score_tracker #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .clear         (init),
        .sample_en     (sample_en),
        .score         (score),
        .score_minimum (score_minimum),
        .best_score    (best_score),
        .best_idx      (best_idx),
        .hit_count     (hit_count),
        .score_cnt     (score_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (init)
            state_d = S_RUN;
        else if (state_q == S_RUN && done_set)
            state_d = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // set beats the STATUS read clear
    always_ff @(posedge clk) begin
        if (rst || init)
            done_q <= 1'b0;
        else if (done_set)
            done_q <= 1'b1;
        else if (status_rd)
            done_q <= 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_s0_address)
            ADDR_W'(AI_REG_STATUS): begin
                rd_mux[STAT_BUSY] = (state_q == S_RUN);
                rd_mux[STAT_DONE] = done_q;
                rd_mux[STAT_HIT]  = (hit_count != '0);
            end
            ADDR_W'(AI_REG_BEST):   rd_mux = 32'(best_score);
            ADDR_W'(AI_REG_RESULT): rd_mux = {16'(best_idx), 16'(hit_count)};
            ADDR_W'(AI_REG_COUNT):  rd_mux = {16'h0, 16'(score_cnt)};
            default:                rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
        end else begin
            avs_s0_readdatavalid <= avs_s0_read;
            if (avs_s0_read)
                avs_s0_readdata <= rd_mux;
        end
    end

`ifdef AI_AV_READER_IRQ_EN
    logic irq_mask;

    always_ff @(posedge clk) begin
        if (rst)
            irq_mask <= 1'b0;
        else if (avs_s0_write && avs_s0_address == ADDR_W'(AI_REG_STATUS))
            irq_mask <= avs_s0_writedata[0];
    end

    assign irq = done_q & irq_mask;
`endif

endmodule

// File: tb/tb_ai_av_reader.sv
// tb/tb_ai_av_reader.sv - directed scoreboard bench for ai_av_reader
module tb_ai_av_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        init = 1'b0;
    logic [7:0]  smin = 8'h10;
    logic        sv = 1'b0;
    logic [23:0] sc = '0;
    logic        sl = 1'b0;
`ifdef AI_AV_READER_IRQ_EN
    logic        wr = 1'b0;
    logic [31:0] wd = '0;
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    ai_av_reader dut (
        .clk                  (clk),
        .rst                  (rst),
        .avs_s0_read          (rd),
        .avs_s0_address       (addr),
        .avs_s0_readdata      (rdata),
        .avs_s0_readdatavalid (rvalid),
`ifdef AI_AV_READER_IRQ_EN
        .avs_s0_write         (wr),
        .avs_s0_writedata     (wd),
        .irq                  (irq),
`endif
        .init                 (init),
        .score_minimum        (smin),
        .score_valid          (sv),
        .score                (sc),
        .score_last           (sl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every readdatavalid pops one expected word and its issue cycle
    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed=1 expected=0 cyc=%0d", cyc);
            end
            if (exp_q.size() != 0) begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic int c = cyc_q.pop_front();
                checks++;
                assert (rdata === e) else begin
                    failures++;
                    $error("FAIL readdata observed=%h expected=%h", rdata, e);
                end
                checks++;
                assert (cyc === c + 1) else begin
                    failures++;
                    $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, c + 1);
                end
            end
        end
    end

    task automatic rd_exp(input logic [3:0] a, input logic [31:0] e);
        rd = 1'b1;
        addr = a;
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic send(input logic [23:0] s, input logic last);
        sv = 1'b1;
        sc = s;
        sl = last;
        @(posedge clk); #1;
        sv = 1'b0;
        sl = 1'b0;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL %s pending_reads observed=%0d expected=0", tag, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (rvalid === 1'b0) else begin
            failures++;
            $error("FAIL reset_valid observed=%b expected=0", rvalid);
        end
        checks++;
        assert (rdata === 32'h0) else begin
            failures++;
            $error("FAIL reset_data observed=%h expected=0", rdata);
        end
        rst = 1'b0;
        rd_exp(4'd0, 32'h0);
        rd_exp(4'd7, 32'h0);
        drain("reset_read");

`ifdef AI_AV_READER_IRQ_EN
        wr = 1'b1; addr = 4'd0; wd = 32'h1;
        @(posedge clk); #1;
        wr = 1'b0;
`endif
        // main run: tie at index 2 keeps index 1
        smin = 8'h10;
        pulse_init();
        send(24'h050000, 1'b0);
        send(24'h200000, 1'b0);
        send(24'h200000, 1'b0);
        send(24'h0F0000, 1'b1);
`ifdef AI_AV_READER_IRQ_EN
        checks++;
        assert (irq === 1'b1) else begin
            failures++;
            $error("FAIL irq_set observed=%b expected=1", irq);
        end
`endif
        rd_exp(4'd1, 32'h0020_0000);
        rd_exp(4'd2, 32'h0001_0002);
        rd_exp(4'd3, 32'h0000_0004);
        rd_exp(4'd0, 32'h0000_0006);
        rd_exp(4'd0, 32'h0000_0004);
        drain("main_run");
`ifdef AI_AV_READER_IRQ_EN
        checks++;
        assert (irq === 1'b0) else begin
            failures++;
            $error("FAIL irq_clear observed=%b expected=0", irq);
        end
`endif

        // DONE ignores further scores
        send(24'h7FFFFF, 1'b1);
        rd_exp(4'd3, 32'h0000_0004);
        rd_exp(4'd1, 32'h0020_0000);
        rd_exp(4'd0, 32'h0000_0004);
        drain("done_ignore");

        // init coincident with a sample drops the sample
        init = 1'b1;
        send(24'h7FFFFF, 1'b0);
        init = 1'b0;
        rd_exp(4'd1, 32'h0);
        rd_exp(4'd3, 32'h0);
        rd_exp(4'd0, 32'h0000_0001);
        send(24'h000001, 1'b1);
        rd_exp(4'd1, 32'h0000_0001);
        rd_exp(4'd2, 32'h0000_0000);
        rd_exp(4'd3, 32'h0000_0001);
        rd_exp(4'd0, 32'h0000_0002);
        drain("init_drop");

        // reset mid-run clears everything and returns to idle
        pulse_init();
        send(24'h100000, 1'b0);
        send(24'h300000, 1'b0);
        send(24'h200000, 1'b0);
        rd_exp(4'd2, 32'h0001_0003);
        drain("pre_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_exp(4'd0, 32'h0);
        rd_exp(4'd1, 32'h0);
        rd_exp(4'd2, 32'h0);
        rd_exp(4'd3, 32'h0);
        send(24'h400000, 1'b1);
        rd_exp(4'd3, 32'h0);
        rd_exp(4'd0, 32'h0);
        drain("mid_run_reset");

        // done set coincident with a STATUS read: set wins
        pulse_init();
        sv = 1'b1; sc = 24'h200000; sl = 1'b1;
        rd_exp(4'd0, 32'h0000_0001);
        sv = 1'b0; sl = 1'b0;
        rd_exp(4'd0, 32'h0000_0006);
        rd_exp(4'd0, 32'h0000_0004);
        drain("set_vs_clear");

        // init coincident with a STATUS read leaves done cleared
        pulse_init();
        send(24'h200000, 1'b1);
        init = 1'b1;
        rd_exp(4'd0, 32'h0000_0006);
        init = 1'b0;
        rd_exp(4'd0, 32'h0000_0001);
        drain("init_vs_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
